// File: rtl/uart_rx_wb.sv
// uart_rx_wb: 8N1 serial receiver with a Wishbone B4 classic slave port.
// The receiver oversamples rx at 16x the bit rate. Received bytes go into a
// small FIFO that the CPU drains through the DATA register.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   cyc/stb/we    Wishbone cycle, strobe, write enable
//   adr[31:0]     byte address, adr[3:2] selects the register
//   dat_i[31:0]   write data
//   dat_o[31:0]   read data, registered, held between transfers
//   ack           one-clock acknowledge, registered
//   rx            asynchronous serial input, idle high
//   irq           level interrupt: FIFO non-empty or OVR or FERR
//
// Registers (adr[3:2]):
//   0 DATA   RO  {23'b0, valid, byte}; reading a non-empty FIFO pops it
//   1 STATUS     [0] NE, [1] FULL, [2] OVR (W1C), [3] FERR (W1C), [7:4] count (sat 15)
//   2 BAUD   RW  [15:0] clk cycles per 1/16 bit
//   3 -      reads 0
//
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | timing to mid start bit, rejects glitches
// DATA   | sampling 8 data bits, LSB first, once every 16 ticks
// STOP   | sampling the stop bit, pushing the byte or flagging errors
// BREAK  | framing error seen, waiting for the line to return high
module uart_rx_wb #(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BAUD_DIV_RST = 16'd27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack,
  input  logic        rx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic [15:0]      r_div;
  logic [15:0]      r_tick_cnt;
  state_t           r_state;
  logic [3:0]       r_tcnt;
  logic [2:0]       r_bidx;
  logic [7:0]       r_shift;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic             r_ovr;
  logic             r_ferr;
  logic             r_ack;
  logic [31:0]      r_dat_o;
  logic             r_irq;

  state_t           w_state_nxt;
  logic [3:0]       w_tcnt_nxt;
  logic [2:0]       w_bidx_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_push_req;
  logic             w_ferr_set;
  logic [15:0]      w_div_eff;
  logic             w_tick;
  logic             w_xfer;
  logic             w_rd;
  logic             w_wr;
  logic [1:0]       w_sel;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_ovr_set;
  logic             w_baud_wr;
  logic             w_stat_wr;
  logic [3:0]       w_cnt_sat;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_unused = ^{adr[31:4], adr[1:0], dat_i[31:16]};

  // rx synchronizer; idle-high reset keeps the FSM quiet coming out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Bus decode; side effects fire on the edge that raises ack
  assign w_xfer    = cyc & stb & ~r_ack;
  assign w_rd      = w_xfer & ~we;
  assign w_wr      = w_xfer & we;
  assign w_sel     = adr[3:2];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop     = w_rd & (w_sel == 2'd0) & ~w_empty;
  // A pop in the same clock frees a slot, so a push into a full FIFO still lands
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovr_set = w_push_req & w_full & ~w_pop;
  assign w_baud_wr = w_wr & (w_sel == 2'd2);
  assign w_stat_wr = w_wr & (w_sel == 2'd1);

  // 16x tick generator; a divisor of 0 behaves as 1
  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_tick    = (r_tick_cnt == (w_div_eff - 16'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div      <= BAUD_DIV_RST;
      r_tick_cnt <= 16'd0;
    end else begin
      if (w_baud_wr) r_div <= dat_i[15:0];
      if (w_baud_wr || w_tick) r_tick_cnt <= 16'd0;
      else                     r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  // Receive FSM: state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tcnt  <= 4'd0;
      r_bidx  <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bidx  <= w_bidx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bidx_nxt  = r_bidx;
    w_shift_nxt = r_shift;
    w_push_req  = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_sync) begin
          w_tcnt_nxt  = 4'd0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_tcnt == 4'd7) begin
            if (r_rx_sync) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_tcnt_nxt  = 4'd0;
              w_bidx_nxt  = 3'd0;
              w_state_nxt = S_DATA;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_tcnt == 4'd15) begin
            w_shift_nxt[r_bidx] = r_rx_sync;
            w_tcnt_nxt          = 4'd0;
            if (r_bidx == 3'd7) w_state_nxt = S_STOP;
            else                w_bidx_nxt  = r_bidx + 3'd1;
          end else begin
            w_tcnt_nxt = r_tcnt + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_tcnt == 4'd15) begin
            if (r_rx_sync) begin
              w_push_req  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr_set  = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + 4'd1;
          end
        end
      end
      S_BREAK: begin
        if (r_rx_sync) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Receive FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'd0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= r_shift;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags; a new event wins over a same-clock clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_ovr_set)                  r_ovr <= 1'b1;
      else if (w_stat_wr && dat_i[2]) r_ovr <= 1'b0;
      if (w_ferr_set)                 r_ferr <= 1'b1;
      else if (w_stat_wr && dat_i[3]) r_ferr <= 1'b0;
    end
  end

  assign w_cnt_sat = (int'(r_count) > 15) ? 4'd15 : 4'(r_count);

  always_comb begin
    w_rdata = 32'd0;
    case (w_sel)
      2'd0:    w_rdata = w_empty ? 32'd0 : {23'd0, 1'b1, r_mem[r_head]};
      2'd1:    w_rdata = {24'd0, w_cnt_sat, r_ferr, r_ovr, w_full, ~w_empty};
      2'd2:    w_rdata = {16'd0, r_div};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack   <= 1'b0;
      r_dat_o <= 32'd0;
      r_irq   <= 1'b0;
    end else begin
      r_ack <= w_xfer;
      if (w_rd) r_dat_o <= w_rdata;
      r_irq <= ~w_empty | r_ovr | r_ferr;
    end
  end

  assign ack   = r_ack;
  assign dat_o = r_dat_o;
  assign irq   = r_irq;

endmodule

// File: tb/tb_uart_rx_wb.sv
// Testbench for uart_rx_wb: drives 8N1 frames on rx, drains the FIFO over
// Wishbone and compares against a queue-based model of the receiver.
module tb_uart_rx_wb;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        rx;
  logic        irq;

  int vectors;
  int miscompares;

  // Reference model: received bytes waiting to be read, plus sticky flags
  logic [7:0] q[$];
  logic       m_ovr;
  logic       m_ferr;

  uart_rx_wb #(.FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(16'd27)) dut (
    .clk   (clk),
    .rst   (rst),
    .cyc   (cyc),
    .stb   (stb),
    .we    (we),
    .adr   (adr),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .ack   (ack),
    .rx    (rx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_status();
    int         c;
    logic [3:0] cs;
    c  = q.size();
    cs = (c > 15) ? 4'd15 : 4'(c);
    return {24'd0, cs, m_ferr, m_ovr, (c == DEPTH), (c != 0)};
  endfunction

  task automatic m_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else                  m_ovr = 1'b1;
  endtask

  task automatic m_pop(output logic [31:0] e);
    if (q.size() != 0) e = {23'd0, 1'b1, q.pop_front()};
    else               e = 32'd0;
  endtask

  task automatic m_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {28'd0, a, 2'b00}; dat_i = 32'd0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    if (!ack) begin
      vectors++;
      miscompares++;
      $display("FAIL wb_read_timeout adr=%0d ack=%b required=1", a, ack);
      d = 32'hDEAD_BEEF;
    end else begin
      d = dat_o;
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] v);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {28'd0, a, 2'b00}; dat_i = v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    if (!ack) begin
      vectors++;
      miscompares++;
      $display("FAIL wb_write_timeout adr=%0d ack=%b required=1", a, ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // One frame: start, 8 data bits LSB first, stop level, optional extra low time
  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_lvl,
                            input int hold_low);
    rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bc) @(negedge clk);
    end
    rx = stop_lvl;
    repeat (bc) @(negedge clk);
    if (!stop_lvl) repeat (hold_low) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0; rx = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; dat_i = 32'd0;
    m_reset();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (dat_o !== 32'd0) begin
      miscompares++; $display("FAIL reset_dat_o got=%h exp=%h", dat_o, 32'd0);
    end
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++; $display("FAIL reset_ack got=%b exp=0", ack);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++; $display("FAIL reset_irq got=%b exp=0", irq);
    end
    repeat (200) @(negedge clk);
    wb_read(2'd1, d);
    vectors++;
    if (d !== 32'h00) begin
      miscompares++; $display("FAIL reset_status got=%h exp=%h", d, 32'h00);
    end
    wb_read(2'd2, d);
    vectors++;
    if (d !== 32'd27) begin
      miscompares++; $display("FAIL reset_baud got=%h exp=%h", d, 32'd27);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++; $display("FAIL reset_irq_idle got=%b exp=0", irq);
    end
  endtask

  // cyc/stb held high: ack must toggle, one transfer every two clocks
  task automatic test_handshake();
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (ack !== 1'((i % 2) == 0)) begin
        miscompares++; $display("FAIL handshake_ack step=%0d got=%b exp=%b", i, ack, 1'((i % 2) == 0));
      end
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++; $display("FAIL handshake_idle_ack got=%b exp=0", ack);
    end
  endtask

  task automatic test_two_bytes();
    logic [31:0] d;
    logic [31:0] e;
    send_frame(8'h55, 432, 1'b1, 0); m_push(8'h55);
    send_frame(8'hA3, 432, 1'b1, 0); m_push(8'hA3);
    wb_read(2'd1, d);
    vectors++;
    if (d !== 32'h21) begin
      miscompares++; $display("FAIL two_bytes_status got=%h exp=%h", d, 32'h21);
    end
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++; $display("FAIL two_bytes_irq got=%b exp=1", irq);
    end
    for (int i = 0; i < 3; i++) begin
      wb_read(2'd0, d);
      m_pop(e);
      vectors++;
      if (d !== e) begin
        miscompares++; $display("FAIL two_bytes_data idx=%0d got=%h exp=%h", i, d, e);
      end
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++; $display("FAIL two_bytes_irq_drained got=%b exp=0", irq);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (600) @(negedge clk);
    wb_read(2'd1, d);
    vectors++;
    if (d !== exp_status()) begin
      miscompares++; $display("FAIL glitch_status got=%h exp=%h", d, exp_status());
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++; $display("FAIL glitch_irq got=%b exp=0", irq);
    end
  endtask

  task automatic test_ferr();
    logic [31:0] d;
    send_frame(8'h3C, 432, 1'b0, 300);
    m_ferr = 1'b1;
    repeat (4) @(negedge clk);
    wb_read(2'd1, d);
    vectors++;
    if (d !== 32'h08) begin
      miscompares++; $display("FAIL ferr_status got=%h exp=%h", d, 32'h08);
    end
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++; $display("FAIL ferr_irq got=%b exp=1", irq);
    end
    wb_read(2'd0, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++; $display("FAIL ferr_data_empty got=%h exp=%h", d, 32'd0);
    end
    wb_write(2'd1, 32'h8);
    m_ferr = 1'b0;
    wb_read(2'd1, d);
    vectors++;
    if (d !== 32'h00) begin
      miscompares++; $display("FAIL ferr_cleared_status got=%h exp=%h", d, 32'h00);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++; $display("FAIL ferr_cleared_irq got=%b exp=0", irq);
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [31:0] v;
    v = $urandom;
    wb_write(2'd2, v);
    wb_read(2'd2, d);
    vectors++;
    if (d !== {16'd0, v[15:0]}) begin
      miscompares++; $display("FAIL baud_readback got=%h exp=%h", d, {16'd0, v[15:0]});
    end
    wb_write(2'd3, 32'hFFFF_FFFF);
    wb_read(2'd3, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++; $display("FAIL reg3_read got=%h exp=%h", d, 32'd0);
    end
    wb_write(2'd0, 32'h1FF);
    wb_read(2'd1, d);
    vectors++;
    if (d !== exp_status()) begin
      miscompares++; $display("FAIL data_write_ignored got=%h exp=%h", d, exp_status());
    end
    wb_write(2'd2, 32'd4);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [31:0] e;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 64, 1'b1, 0);
      m_push(8'(i));
    end
    wb_read(2'd1, d);
    vectors++;
    if (d !== 32'hF7) begin
      miscompares++; $display("FAIL overflow_status got=%h exp=%h", d, 32'hF7);
    end
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++; $display("FAIL overflow_irq got=%b exp=1", irq);
    end
    for (int i = 0; i < 17; i++) begin
      wb_read(2'd0, d);
      m_pop(e);
      vectors++;
      if (d !== e) begin
        miscompares++; $display("FAIL overflow_data idx=%0d got=%h exp=%h", i, d, e);
      end
    end
    wb_write(2'd1, 32'h4);
    m_ovr = 1'b0;
    wb_read(2'd1, d);
    vectors++;
    if (d !== 32'h00) begin
      miscompares++; $display("FAIL overflow_cleared_status got=%h exp=%h", d, 32'h00);
    end
  endtask

  // Random bytes at random divisors; first round forces divisor 0 (acts as 1)
  task automatic test_random();
    logic [31:0] d;
    logic [31:0] e;
    logic [7:0]  b;
    int          div;
    int          n;
    for (int r = 0; r < 6; r++) begin
      div = (r == 0) ? 0 : int'($urandom_range(1, 6));
      wb_write(2'd2, 32'(div));
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        send_frame(b, 16 * ((div == 0) ? 1 : div), 1'b1, 0);
        m_push(b);
      end
      wb_read(2'd1, d);
      vectors++;
      if (d !== exp_status()) begin
        miscompares++; $display("FAIL random_status round=%0d got=%h exp=%h", r, d, exp_status());
      end
      for (int i = 0; i <= n; i++) begin
        wb_read(2'd0, d);
        m_pop(e);
        vectors++;
        if (d !== e) begin
          miscompares++; $display("FAIL random_data round=%0d idx=%0d got=%h exp=%h", r, i, d, e);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic [31:0] e;
    wb_write(2'd2, 32'd4);
    send_frame(8'h81, 64, 1'b1, 0);
    m_push(8'h81);
    wb_read(2'd0, d);
    m_pop(e);
    vectors++;
    if (d !== 32'h181) begin
      miscompares++; $display("FAIL midframe_first got=%h exp=%h", d, 32'h181);
    end
    rx = 1'b0;
    repeat (64 * 5) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    m_reset();
    repeat (20) @(negedge clk);
    wb_read(2'd2, d);
    vectors++;
    if (d !== 32'd27) begin
      miscompares++; $display("FAIL midframe_baud_reset got=%h exp=%h", d, 32'd27);
    end
    send_frame(8'h7E, 432, 1'b1, 0);
    m_push(8'h7E);
    wb_read(2'd1, d);
    vectors++;
    if (d !== 32'h11) begin
      miscompares++; $display("FAIL midframe_status got=%h exp=%h", d, 32'h11);
    end
    for (int i = 0; i < 2; i++) begin
      wb_read(2'd0, d);
      m_pop(e);
      vectors++;
      if (d !== e) begin
        miscompares++; $display("FAIL midframe_data idx=%0d got=%h exp=%h", i, d, e);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_handshake();
    test_two_bytes();
    test_glitch();
    test_ferr();
    test_regs();
    test_overflow();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_wb.md
Name: uart_rx_wb

Overview:
- Wishbone B4 classic slave; serial UART receiver, 8N1 framing.
- Input path to pair with the console transmitter.
- Received bytes are buffered in a small FIFO; the CPU reads them over the data bus through the cross bar.
- Status flags and a level interrupt expose data availability and errors.

Parameters:
- FIFO_DEPTH, 16, receive FIFO entries; power of two, minimum 2.
- BAUD_DIV_RST, 27, reset value of the divisor register: clk cycles per 1/16 bit period (50 MHz, 115200 baud).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- cyc  input  1  Wishbone cycle.
- stb  input  1  Wishbone strobe.
- we  input  1  Wishbone write enable.
- adr  input  32  byte address; only adr[3:2] is decoded.
- dat_i  input  32  write data.
- dat_o  output  32  read data.
- ack  output  1  Wishbone acknowledge.
- rx  input  1  asynchronous serial input; idle high.
- irq  output  1  high while the FIFO is non-empty, or while the OVR or FERR flag is set.

Behaviour:
- Reset (rst low, asynchronous): all registers and outputs clear, with these exceptions:
  - The rx synchronizer flops reset to 1.
  - The divisor resets to BAUD_DIV_RST.
  - The FSM resets to IDLE.
  - dat_o=0, ack=0, irq=0, FIFO empty, sticky flags 0.
  - A frame in progress when reset asserts is discarded.
- rx synchronization: 2-flop synchronizer; the FSM uses only the synchronized value.
- Tick generator: a 16-bit counter counts 0..DIV-1; tick pulses for one clk when the counter equals DIV-1, then the counter returns to 0. A DIV value of 0 is treated as 1. Writing BAUD clears the counter.
- Receive FSM, with a 4-bit tick count and a 3-bit bit index:
  - IDLE: on synchronized rx=0, clear the tick count and go to START.
  - START: after 8 ticks (mid start bit), sample rx. If rx=1 (glitch), return to IDLE. If rx=0, clear the count and go to DATA.
  - DATA: every 16 ticks, shift the sample into bit[index], LSB first. After bit 7, go to STOP.
  - STOP: after 16 ticks, sample rx.
    - rx=1 and FIFO not full: push the byte; go to IDLE.
    - rx=1 and FIFO full: drop the byte, set OVR; go to IDLE.
    - rx=0: set FERR, discard the byte, go to BREAK.
  - BREAK: wait for synchronized rx=1, then go to IDLE.
- Register map, selected by adr[3:2]:
  - 0 DATA, read-only.
    - FIFO non-empty: dat_o={23'b0, 1'b1, head[7:0]}, and the FIFO pops on the ack cycle.
    - FIFO empty: dat_o=0, no pop.
    - Writes are ignored.
  - 1 STATUS: bit0 NE (FIFO not empty), bit1 FULL, bit2 OVR (sticky), bit3 FERR (sticky), bits[7:4] FIFO count saturated to 15. Writing with dat_i[2] or dat_i[3] set clears that flag (write-1-to-clear).
  - 2 BAUD: read/write; [15:0] divisor; upper bits read 0.
  - 3: reads 0; writes ignored.
- Wishbone handshake:
  - ack rises one clk after cyc&stb is sampled high with ack low.
  - ack lasts exactly one clk; there is no combinational ack.
  - One transfer per two clks minimum.
  - dat_o is valid while ack=1 and holds its value otherwise.
  - Every address acks; there is no err.
- Side effects (pop, flag clear, BAUD write) occur in the ack cycle only, once per transfer.
- Simultaneous events:
  - Push and pop in the same clk: count unchanged; data ordering preserved.
  - Push when full with a pop in the same clk: the push succeeds; no OVR.
  - A flag-clear write in the same clk as a new flag event: the set wins.
- FIFO: head/tail pointers wrap modulo FIFO_DEPTH; full when count==FIFO_DEPTH.
- irq is registered: (count!=0)|OVR|FERR, updated every clk.

Test Plan:
- Reset with rx=1, then read STATUS and BAUD -> STATUS=0x00, BAUD=27, irq=0, no FSM activity.
- Send 0x55 then 0xA3 at DIV=27 (432 clk/bit) -> STATUS=0x21, irq=1; DATA reads 0x155 then 0x1A3; third DATA read returns 0x000; irq=0.
- Apply a 0-pulse of 100 clk on rx (shorter than a half bit) -> FSM returns to IDLE; FIFO count stays 0; no FERR.
- Send byte 0x3C with stop bit driven 0, then release rx -> FERR=1, STATUS=0x08, irq=1, FIFO empty; write STATUS 0x8 -> STATUS=0x00, irq=0.
- Send 17 bytes 0x00..0x10 without reading -> FULL=1, OVR=1, count field=15, STATUS=0x0F7; 16 DATA reads return 0x100..0x10F; byte 0x10 is lost.
- Write BAUD=4, then send 0x81 at 64 clk/bit -> DATA=0x181. Assert rst mid-byte, release, send 0x7E -> only 0x7E is received.
